window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Builds the 3x3 neighbourhood that feeds the combinational median filter.
//  Input is a raster pixel stream from the VGA capture/frame path.
//  Two IMG_WIDTH-deep line buffers plus a 3x3 shift register present nine
//  registered pixels p0..p8 with a valid strobe and the centre coordinate.
//  Sits directly upstream of the median stage.
// PARAMETERS
//  bit_width   8    pixel width; matches the median stage
//  IMG_WIDTH   640  active pixels per line
//  IMG_HEIGHT  480  active lines per frame
// PORTS
//  clk        in   1          single system clock
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          in_data holds a pixel this cycle
//  in_sof     in   1          first pixel of a frame; qualified by in_valid
//  in_data    in   bit_width  raster-order pixel
//  p0..p8     out  bit_width  window pixels
//                             p0 p1 p2 = top (oldest) line, left to right
//                             p3 p4 p5 = middle line; p4 is the centre
//                             p6 p7 p8 = newest line
//  out_valid  out  1          p0..p8, out_x and out_y are valid this cycle
//  out_x      out  10         centre column, 0..IMG_WIDTH-1
//  out_y      out  9          centre row, 0..IMG_HEIGHT-1
//  frame_done out  1          one-cycle pulse after the last pixel of a frame
// BEHAVIOUR
//  - Reset: all outputs 0, col/row counters 0, FSM = IDLE.
//    Line-buffer contents are don't-care.
//  - FSM
//    IDLE: ignores all input until in_valid && in_sof, then goes to ACTIVE;
//          that pixel is stored as (col 0, row 0).
//    ACTIVE: each in_valid pixel is written at col, and col increments.
//          At col = IMG_WIDTH-1, col wraps to 0 and row increments.
//          Accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1) pulses frame_done on
//          the next cycle and returns the FSM to IDLE.
//  - in_valid && in_sof while ACTIVE: resync. That pixel becomes (0,0).
//    Counters restart. No out_valid is produced for the abandoned frame
//    from that cycle on, and no frame_done pulses for it.
//  - in_valid low: stall. Counters, shift register and outputs hold, and
//    out_valid = 0. Gaps of any length are legal, including between lines.
//  - Line buffers: read at col, then write in_data at col in the same
//    cycle (read-before-write).
//    lb1 holds row r-1 and lb0 holds row r-2, relative to the current row r.
//    Column shift: p2 <= lb0[col], p5 <= lb1[col], p8 <= in_data;
//    p1 <= p2, p0 <= p1, and likewise for the other rows.
//  - out_valid: asserted one cycle after accepting pixel (col,row) when
//    row >= 2 and col >= 2.
//    At that point out_x = col-1, out_y = row-1, and p4 = pixel(col-1,row-1).
//    Border centres (x = 0, x = W-1, y = 0, y = H-1) are never emitted;
//    downstream passes those pixels unfiltered.
//  - Latency: in_data to p8 is 1 clk. Valid windows per frame:
//    (IMG_WIDTH-2) * (IMG_HEIGHT-2).
//  - Line wrap: the shift register is not cleared at col 0. Windows with
//    col < 2 are suppressed by the out_valid rule, so no cross-line window
//    is ever flagged valid.
//  - Reset mid-frame: takes effect immediately, and the next frame requires
//    in_sof.
//    Pixels arriving in IDLE without in_sof (including a frame overrun) are
//    dropped.
//  - Counter widths: col needs ceil(log2(IMG_WIDTH)) bits and row needs
//    ceil(log2(IMG_HEIGHT)) bits. The port widths above hold for the
//    defaults.
// TESTING
//  1 W=8, H=6, pixel(x,y) = 16y+x, in_valid always high -> first out_valid
//    1 clk after pixel (2,2): out_x=1, out_y=1, p0..p8 =
//    00,01,02,10,11,12,20,21,22. Exactly 24 valid windows;
//    frame_done pulses once.
//  2 Same frame with in_valid randomly low 50% of cycles -> identical
//    window sequence; out_valid never high in a stall cycle.
//  3 in_sof re-asserted at pixel (3,4) of a frame -> restart at (0,0);
//    no window mixes old-frame and new-frame rows; no frame_done for the
//    aborted frame.
//  4 Pixels without in_sof after reset -> no out_valid and no buffer-driven
//    output. The first in_sof starts a normal frame.
//  5 rst pulsed asynchronously mid-line (between clk edges) -> all outputs
//    0 immediately; the next full frame matches scenario 1.
//  6 Chain into the median stage with a constant 0x80 frame containing a
//    single 0xFF at (4,3) -> median output 0x80 at every valid centre,
//    including (4,3).

Source files
------------

// File: rtl/window_3x3_gen.sv
//------------------------------------------------------------------------------
// window_3x3_gen
//   Builds the 3x3 pixel neighbourhood for the median filter from a raster
//   pixel stream. Two IMG_WIDTH-deep line buffers hold the two previous rows;
//   a 3x3 shift register presents nine registered pixels with a valid strobe
//   and the coordinate of the centre pixel. Border centres are never flagged.
//
// Ports
//   clk        in   1          system clock
//   rst        in   1          asynchronous, active-high reset
//   in_valid   in   1          in_data carries a pixel this cycle
//   in_sof     in   1          first pixel of a frame (qualified by in_valid)
//   in_data    in   bit_width  raster-order pixel
//   p0..p8     out  bit_width  window: p0-p2 oldest row, p3-p5 middle row
//                              (p4 = centre), p6-p8 newest row; left to right
//   out_valid  out  1          window and coordinates valid this cycle
//   out_x      out  10         centre column
//   out_y      out  9          centre row
//   frame_done out  1          one-cycle pulse after the last pixel of a frame
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module window_3x3_gen #(
   parameter int bit_width  = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [bit_width-1:0] in_data,
   output logic [bit_width-1:0] p0,
   output logic [bit_width-1:0] p1,
   output logic [bit_width-1:0] p2,
   output logic [bit_width-1:0] p3,
   output logic [bit_width-1:0] p4,
   output logic [bit_width-1:0] p5,
   output logic [bit_width-1:0] p6,
   output logic [bit_width-1:0] p7,
   output logic [bit_width-1:0] p8,
   output logic                 out_valid,
   output logic [9:0]           out_x,
   output logic [8:0]           out_y,
   output logic                 frame_done
);

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t               r_state;
   logic [COL_W-1:0]     r_col;
   logic [ROW_W-1:0]     r_row;
   logic [bit_width-1:0] r_lb0 [IMG_WIDTH];   // row r-2
   logic [bit_width-1:0] r_lb1 [IMG_WIDTH];   // row r-1

   logic                 w_accept;
   logic [COL_W-1:0]     w_col;
   logic [ROW_W-1:0]     w_row;
   logic [bit_width-1:0] w_lb0_rd;
   logic [bit_width-1:0] w_lb1_rd;
   logic                 w_win_valid;

   // A start-of-frame pixel is accepted from any state and is always (0,0),
   // which also covers resynchronisation in the middle of a frame.
   assign w_accept    = in_valid && (in_sof || (r_state == S_ACTIVE));
   assign w_col       = in_sof ? '0 : r_col;
   assign w_row       = in_sof ? '0 : r_row;
   assign w_lb0_rd    = r_lb0[w_col];
   assign w_lb1_rd    = r_lb1[w_col];
   assign w_win_valid = (w_col >= COL_TWO) && (w_row >= ROW_TWO);

   // NOTE: the line buffers carry no reset so they can map onto RAM; stale
   // contents never reach a valid window because rows 0 and 1 of each frame
   // overwrite every column before row 2 reads them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         // NOTE: non-blocking writes make this read-before-write: the reads
         // above see the old contents, so lb1's old row drops into lb0.
         r_lb0[w_col] <= w_lb1_rd;
         r_lb1[w_col] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_col      <= '0;
         r_row      <= '0;
         p0         <= '0;
         p1         <= '0;
         p2         <= '0;
         p3         <= '0;
         p4         <= '0;
         p5         <= '0;
         p6         <= '0;
         p7         <= '0;
         p8         <= '0;
         out_valid  <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (w_accept) begin
            // Shift left; the shift register is not cleared at line start,
            // the col >= 2 rule keeps cross-line windows from being flagged.
            p0 <= p1;
            p1 <= p2;
            p2 <= w_lb0_rd;
            p3 <= p4;
            p4 <= p5;
            p5 <= w_lb1_rd;
            p6 <= p7;
            p7 <= p8;
            p8 <= in_data;

            out_valid <= w_win_valid;
            if (w_win_valid) begin
               out_x <= 10'(w_col - COL_ONE);
               out_y <= 9'(w_row - ROW_ONE);
            end

            r_state <= S_ACTIVE;
            if (w_col == LAST_COL) begin
               r_col <= '0;
               if (w_row == LAST_ROW) begin
                  r_row      <= '0;
                  r_state    <= S_IDLE;
                  frame_done <= 1'b1;
               end else begin
                  r_row <= w_row + ROW_ONE;
               end
            end else begin
               r_col <= w_col + COL_ONE;
               r_row <= w_row;
            end
         end
      end
   end

endmodule

// File: tb/tb_window_3x3_gen.sv
//------------------------------------------------------------------------------
// tb_window_3x3_gen
//   Lock-step bench for window_3x3_gen on an 8x6 image. Each record of the
//   vector table is one clock: the inputs driven and the outputs expected
//   just after the following rising edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_window_3x3_gen;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_sof;
   logic [BW-1:0] in_data;
   logic [BW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
   logic          out_valid;
   logic [9:0]    out_x;
   logic [8:0]    out_y;
   logic          frame_done;
   logic [71:0]   w_pbus;

   always #5 clk = ~clk;

   window_3x3_gen #(
      .bit_width (BW),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .p0        (p0),
      .p1        (p1),
      .p2        (p2),
      .p3        (p3),
      .p4        (p4),
      .p5        (p5),
      .p6        (p6),
      .p7        (p7),
      .p8        (p8),
      .out_valid (out_valid),
      .out_x     (out_x),
      .out_y     (out_y),
      .frame_done(frame_done)
   );

   assign w_pbus = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

   typedef struct {
      logic        v;     // in_valid
      logic        sof;   // in_sof
      logic [7:0]  d;     // in_data
      logic        ev;    // expected out_valid
      logic [9:0]  ex;    // expected out_x
      logic [8:0]  ey;    // expected out_y
      logic [71:0] ep;    // expected {p8..p0}
      logic        efd;   // expected frame_done
      logic        med;   // also check median of the window is 0x80
   } vec_t;

   vec_t        tbl[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          win_cnt;
   int          fd_cnt;
   logic [71:0] first_p;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // mode 0: base + 16*y + x;  mode 1: flat 0x80 with a single 0xFF at (4,3)
   function automatic logic [7:0] pix(input int mode, input int base, input int x, input int y);
      if (mode == 0) return 8'(base + 16 * y + x);
      return (x == 4 && y == 3) ? 8'hFF : 8'h80;
   endfunction

   function automatic logic [7:0] med9(input logic [71:0] w);
      logic [7:0] a [9];
      logic [7:0] t;
      for (int k = 0; k < 9; k++) a[k] = w[8*k +: 8];
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return a[4];
   endfunction

   function automatic void add_stall();
      vec_t s;
      s     = '{default: '0};
      s.sof = 1'($urandom_range(1, 0));   // in_sof without in_valid must be ignored
      s.d   = 8'hEE;
      tbl.push_back(s);
   endfunction

   // Raster pixels 0..npix-1 of a frame (first one carries in_sof) with the
   // expected window after each accepted pixel.
   function automatic void add_frame(input int mode, input int base, input int npix,
                                     input bit stalls, input bit med);
      for (int n = 0; n < npix; n++) begin
         vec_t v;
         int   x;
         int   y;
         x = n % W;
         y = n / W;
         if (stalls && $urandom_range(1, 0) == 1)
            repeat ($urandom_range(3, 1)) add_stall();
         v     = '{default: '0};
         v.v   = 1'b1;
         v.sof = (n == 0);
         v.d   = pix(mode, base, x, y);
         v.ev  = (x >= 2) && (y >= 2);
         v.efd = (x == W - 1) && (y == H - 1);
         v.med = med;
         if (v.ev) begin
            v.ex = 10'(x - 1);
            v.ey = 9'(y - 1);
            for (int k = 0; k < 9; k++)
               v.ep[8*k +: 8] = pix(mode, base, x - 2 + k % 3, y - 2 + k / 3);
         end
         tbl.push_back(v);
      end
   endfunction

   // Drive each record on the falling edge, compare 1 ns after the next
   // rising edge, and leave the inputs idle at the end.
   task automatic run_table(input string tag);
      win_cnt = 0;
      fd_cnt  = 0;
      first_p = '0;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         in_valid = tbl[i].v;
         in_sof   = tbl[i].sof;
         in_data  = tbl[i].d;
         @(posedge clk);
         #1;
         check($sformatf("%s v%0d out_valid", tag, i), 72'(out_valid), 72'(tbl[i].ev));
         check($sformatf("%s v%0d frame_done", tag, i), 72'(frame_done), 72'(tbl[i].efd));
         if (out_valid === 1'b1) begin
            if (win_cnt == 0) first_p = w_pbus;
            win_cnt++;
         end
         if (frame_done === 1'b1) fd_cnt++;
         if (tbl[i].ev) begin
            check($sformatf("%s v%0d out_x", tag, i), 72'(out_x), 72'(tbl[i].ex));
            check($sformatf("%s v%0d out_y", tag, i), 72'(out_y), 72'(tbl[i].ey));
            check($sformatf("%s v%0d window", tag, i), w_pbus, tbl[i].ep);
            if (tbl[i].med)
               check($sformatf("%s v%0d median", tag, i), 72'(med9(w_pbus)), 72'h80);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      tbl.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " window"},     w_pbus,           72'h0);
      check({tag, " out_valid"},  72'(out_valid),   72'h0);
      check({tag, " out_x"},      72'(out_x),       72'h0);
      check({tag, " out_y"},      72'(out_y),       72'h0);
      check({tag, " frame_done"}, 72'(frame_done),  72'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst      = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time %0t reached, bench expected to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
      do_reset();
      check_all_zero("reset");

      // 1: clean frame, in_valid always high
      add_frame(0, 0, W * H, 1'b0, 1'b0);
      run_table("s1");
      check("s1 first window", first_p, 72'h22_21_20_12_11_10_02_01_00);
      check("s1 window count", 72'(win_cnt), 72'd24);
      check("s1 frame_done count", 72'(fd_cnt), 72'd1);

      // 2: same frame with random stalls, including stalls carrying in_sof
      add_frame(0, 0, W * H, 1'b1, 1'b0);
      run_table("s2");
      check("s2 window count", 72'(win_cnt), 72'd24);
      check("s2 frame_done count", 72'(fd_cnt), 72'd1);

      // 3: resync at pixel (3,4); the old frame yields 13 windows, no frame_done
      add_frame(0, 0, 4 * W + 3, 1'b0, 1'b0);
      add_frame(0, 8'h80, W * H, 1'b0, 1'b0);
      run_table("s3");
      check("s3 window count", 72'(win_cnt), 72'd37);
      check("s3 frame_done count", 72'(fd_cnt), 72'd1);

      // 4: pixels without in_sof after reset are dropped
      do_reset();
      for (int i = 0; i < 20; i++) begin
         vec_t v;
         v   = '{default: '0};
         v.v = 1'b1;
         v.d = 8'hAA;
         tbl.push_back(v);
      end
      run_table("s4 junk");
      check("s4 junk windows", 72'(win_cnt), 72'd0);
      check_all_zero("s4 idle");
      add_frame(0, 0, W * H, 1'b0, 1'b0);
      run_table("s4");
      check("s4 window count", 72'(win_cnt), 72'd24);

      // 5: asynchronous reset between clock edges mid-line
      add_frame(0, 0, 3 * W + 5, 1'b0, 1'b0);
      run_table("s5 part");
      check("s5 valid before reset", 72'(out_valid), 72'h1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("s5 async reset");
      @(negedge clk);
      rst = 1'b0;
      add_frame(0, 0, W * H, 1'b0, 1'b0);
      run_table("s5");
      check("s5 first window", first_p, 72'h22_21_20_12_11_10_02_01_00);
      check("s5 window count", 72'(win_cnt), 72'd24);
      check("s5 frame_done count", 72'(fd_cnt), 72'd1);

      // 6: flat 0x80 frame with one 0xFF at (4,3) into a median model
      add_frame(1, 0, W * H, 1'b0, 1'b1);
      run_table("s6");
      check("s6 window count", 72'(win_cnt), 72'd24);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
